// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the factorial CPU datapath.
//   - DATA_W / NREG : default datapath width and register-file depth
//   - INS_*         : ALU operation encoding on InsSel
//   - SRC_*         : write-data source codes on InMuxAdd
//   - REG_*         : fixed register roles
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int NREG   = 16;

    localparam logic [1:0] INS_NOP = 2'd0;
    localparam logic [1:0] INS_CLR = 2'd1;
    localparam logic [1:0] INS_ADD = 2'd2;
    localparam logic [1:0] INS_SUB = 2'd3;

    localparam logic [2:0] SRC_A     = 3'd0;
    localparam logic [2:0] SRC_CONST = 3'd2;
    localparam logic [2:0] SRC_ALUQ  = 3'd3;
    localparam logic [2:0] SRC_READ  = 3'd4;

    localparam logic [3:0] REG_RESULT = 4'd0;
    localparam logic [3:0] REG_OPA    = 4'd1;
    localparam logic [3:0] REG_OPB    = 4'd2;
    localparam logic [3:0] REG_ACC    = 4'd15;

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREG x DATA_W register file, one synchronous write port,
// one asynchronous read port and fixed taps on the result/operand registers.
// Ports:
//   clk, reset_n          clock, async active-low reset (clears every entry)
//   we, wr_addr, wr_data  write port, takes effect at the rising edge
//   rd_addr, rd_data      combinational read port (pre-edge contents)
//   reg0, reg1, reg2      taps for the result and the two ALU operands
module cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] reg0,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
    assign reg0    = mem[REG_RESULT];
    assign reg1    = mem[REG_OPA];
    assign reg2    = mem[REG_OPB];

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: datapath of the factorial CPU. Executes the control word
// presented each cycle: register file, input mux and an ALU on reg1/reg2.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   A, CUconst          external operand and control-unit constant
//   InsSel              ALU op (NOP/CLR/ADD/SUB)
//   WE, RegAdd          register write enable / address
//   OutMuxAdd           register read address
//   InMuxAdd            write-data source select
//   Z, CO               combinational zero / carry flags of the live ALU output
//   Result, ResultValid reg0 contents and one-cycle pulse after reg0 is written
//   Ovf                 sticky ADD carry (only with CPU_DP_STICKY_OVF_EN)
// Build option: define CPU_DP_STICKY_OVF_EN to enable the sticky Ovf flop;
// otherwise Ovf is tied low.
module cpu_datapath #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] A,
    input  logic [1:0]        InsSel,
    input  logic              WE,
    input  logic [3:0]        RegAdd,
    input  logic [3:0]        OutMuxAdd,
    input  logic [2:0]        InMuxAdd,
    input  logic [DATA_W-1:0] CUconst,
    output logic              Z,
    output logic              CO,
    output logic [DATA_W-1:0] Result,
    output logic              ResultValid,
    output logic              Ovf
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] reg0;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;
    logic              result_valid_q;

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (WE),
        .wr_addr (RegAdd),
        .wr_data (wr_data),
        .rd_addr (OutMuxAdd),
        .rd_data (rd_data),
        .reg0    (reg0),
        .reg1    (op_a),
        .reg2    (op_b)
    );

    // Both results carry an extra top bit: ADD's is the carry, SUB's is the
    // borrow, so "no borrow" (op_a >= op_b) is its inverse.
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_y = alu_q;
        CO    = 1'b0;
        case (InsSel)
            INS_ADD: begin
                alu_y = add_full[DATA_W-1:0];
                CO    = add_full[DATA_W];
            end
            INS_SUB: begin
                alu_y = sub_full[DATA_W-1:0];
                CO    = ~sub_full[DATA_W];
            end
            default: ;
        endcase
    end

    assign Z = (alu_y == '0);

    always_comb begin
        wr_data = '0;
        case (InMuxAdd)
            SRC_A:     wr_data = A;
            SRC_CONST: wr_data = CUconst;
            SRC_ALUQ:  wr_data = alu_q;
            SRC_READ:  wr_data = rd_data;
            default:   wr_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_q <= '0;
        end else if (InsSel == INS_ADD || InsSel == INS_SUB) begin
            alu_q <= alu_y;
        end else if (InsSel == INS_CLR) begin
            alu_q <= '0;
        end
    end

    // Pulses on every reg0 write, even when the stored value does not change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= WE && (RegAdd == REG_RESULT);
        end
    end

    assign Result      = reg0;
    assign ResultValid = result_valid_q;

`ifdef CPU_DP_STICKY_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (InsSel == INS_ADD && add_full[DATA_W]) begin
            ovf_q <= 1'b1;
        end else if (InsSel == INS_CLR) begin
            ovf_q <= 1'b0;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed vector table plus randomized control words
// checked against an arithmetic model of the datapath.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] A;
    logic [1:0] InsSel;
    logic       WE;
    logic [3:0] RegAdd;
    logic [3:0] OutMuxAdd;
    logic [2:0] InMuxAdd;
    logic [7:0] CUconst;
    logic       Z;
    logic       CO;
    logic [7:0] Result;
    logic       ResultValid;
    logic       Ovf;

    cpu_datapath dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .A           (A),
        .InsSel      (InsSel),
        .WE          (WE),
        .RegAdd      (RegAdd),
        .OutMuxAdd   (OutMuxAdd),
        .InMuxAdd    (InMuxAdd),
        .CUconst     (CUconst),
        .Z           (Z),
        .CO          (CO),
        .Result      (Result),
        .ResultValid (ResultValid),
        .Ovf         (Ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ins, we, radd, oadd, src, a, c;
        int z, co, res, rv;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: register contents, ALU result register, sticky flag.
    int m [16];
    int aq;
    int ovf;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 0;
        aq  = 0;
        ovf = 0;
    endtask

    function automatic vec_t mk(int ins, int we, int radd, int oadd, int src,
                                int a, int c, int z, int co, int res, int rv);
        vec_t v;
        v.ins = ins; v.we = we; v.radd = radd; v.oadd = oadd; v.src = src;
        v.a = a; v.c = c; v.z = z; v.co = co; v.res = res; v.rv = rv;
        return v;
    endfunction

    // Called at posedge+1. Flags are checked mid-cycle, outputs after the edge.
    task automatic apply(input vec_t v, input bit directed, input string tag);
        int r1, r2, y, co, z, wd;
        InsSel    = v.ins[1:0];
        WE        = v.we[0];
        RegAdd    = v.radd[3:0];
        OutMuxAdd = v.oadd[3:0];
        InMuxAdd  = v.src[2:0];
        A         = v.a[7:0];
        CUconst   = v.c[7:0];
        r1 = m[1];
        r2 = m[2];
        case (v.ins)
            2:       begin y = (r1 + r2) % 256;       co = (r1 + r2 > 255) ? 1 : 0; end
            3:       begin y = (r1 - r2 + 256) % 256; co = (r1 >= r2) ? 1 : 0; end
            default: begin y = aq;                    co = 0; end
        endcase
        z = (y == 0) ? 1 : 0;
        case (v.src)
            0:       wd = v.a;
            2:       wd = v.c;
            3:       wd = aq;
            4:       wd = m[v.oadd];
            default: wd = 0;
        endcase
        #1;
        chk({tag, " Z"},  int'(Z),  directed ? v.z  : z);
        chk({tag, " CO"}, int'(CO), directed ? v.co : co);
        @(posedge clk);
        if (v.ins == 2 || v.ins == 3) aq = y;
        else if (v.ins == 1) aq = 0;
`ifdef CPU_DP_STICKY_OVF_EN
        if (v.ins == 2 && co == 1) ovf = 1;
        else if (v.ins == 1) ovf = 0;
`endif
        if (v.we != 0) m[v.radd] = wd;
        #1;
        chk({tag, " Result"}, int'(Result), directed ? v.res : m[0]);
        chk({tag, " ResultValid"}, int'(ResultValid),
            directed ? v.rv : ((v.we != 0 && v.radd == 0) ? 1 : 0));
        chk({tag, " Ovf"}, int'(Ovf), ovf);
    endtask

    initial begin
        vec_t v;
        //          ins we radd oadd src a     c      z  co res   rv
        tbl.push_back(mk(0, 1,  1,  0,  0,  5,    0,     1, 0, 0,    0));
        tbl.push_back(mk(0, 1,  2,  0,  2,  0,    8'hFF, 1, 0, 0,    0));
        tbl.push_back(mk(2, 0,  0,  0,  0,  0,    0,     0, 1, 0,    0));
        tbl.push_back(mk(0, 1,  1,  0,  3,  0,    0,     0, 0, 0,    0));
        tbl.push_back(mk(0, 1,  0,  1,  4,  0,    0,     0, 0, 4,    1));
        tbl.push_back(mk(0, 1,  1,  0,  2,  0,    1,     0, 0, 4,    0));
        tbl.push_back(mk(2, 0,  0,  0,  0,  0,    0,     1, 1, 4,    0));
        tbl.push_back(mk(0, 1,  1,  0,  0,  2,    0,     1, 0, 4,    0));
        tbl.push_back(mk(2, 0,  0,  0,  0,  0,    0,     0, 1, 4,    0));
        tbl.push_back(mk(0, 1,  1,  0,  3,  0,    0,     0, 0, 4,    0));
        tbl.push_back(mk(2, 0,  0,  0,  0,  0,    0,     1, 1, 4,    0));
        tbl.push_back(mk(3, 0,  0,  0,  0,  0,    0,     0, 0, 4,    0));
        tbl.push_back(mk(0, 1,  2,  0,  2,  0,    1,     0, 0, 4,    0));
        tbl.push_back(mk(3, 0,  0,  0,  0,  0,    0,     1, 1, 4,    0));
        tbl.push_back(mk(1, 1, 15,  0,  2,  0,    8'h18, 1, 0, 4,    0));
        tbl.push_back(mk(0, 1,  0, 15,  4,  0,    0,     1, 0, 8'h18, 1));
        tbl.push_back(mk(0, 0,  0,  0,  0,  0,    0,     1, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1,  0, 15,  4,  0,    0,     1, 0, 8'h18, 1));
        tbl.push_back(mk(0, 0,  0,  0,  0,  0,    0,     1, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1, 15,  0,  0,  6,    0,     1, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1,  3, 15,  4,  0,    0,     1, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1, 15,  0,  2,  0,    9,     1, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1, 15, 15,  4,  0,    0,     1, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1,  0,  3,  4,  0,    0,     1, 0, 6,    1));
        tbl.push_back(mk(0, 1,  0, 15,  4,  0,    0,     1, 0, 9,    1));
        tbl.push_back(mk(2, 1,  1,  0,  2,  0,    8'h80, 0, 0, 9,    0));
        tbl.push_back(mk(0, 1,  0,  0,  3,  0,    0,     0, 0, 2,    1));
        tbl.push_back(mk(2, 0,  0,  0,  0,  0,    0,     0, 0, 2,    0));
        tbl.push_back(mk(0, 1,  0,  0,  0,  7,    0,     0, 0, 7,    1));
        tbl.push_back(mk(0, 1,  0,  0,  5,  7,    7,     0, 0, 0,    1));
        tbl.push_back(mk(0, 1,  0,  0,  0,  9,    0,     0, 0, 9,    1));
        tbl.push_back(mk(0, 1,  0,  0,  7,  9,    9,     0, 0, 0,    1));
        tbl.push_back(mk(1, 0,  0,  0,  0,  0,    0,     0, 0, 0,    0));
        tbl.push_back(mk(0, 1,  1,  0,  2,  0,    8'hC8, 1, 0, 0,    0));
        tbl.push_back(mk(0, 1,  2,  0,  2,  0,    8'h64, 1, 0, 0,    0));
        tbl.push_back(mk(2, 0,  0,  0,  0,  0,    0,     0, 1, 0,    0));
        tbl.push_back(mk(1, 0,  0,  0,  0,  0,    0,     0, 0, 0,    0));
        tbl.push_back(mk(0, 0,  0,  0,  0,  0,    0,     1, 0, 0,    0));

        reset_n = 1'b0;
        A = '0; InsSel = '0; WE = 1'b0; RegAdd = '0; OutMuxAdd = '0;
        InMuxAdd = '0; CUconst = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset Z", int'(Z), 1);
        chk("reset CO", int'(CO), 0);
        chk("reset Result", int'(Result), 0);
        chk("reset ResultValid", int'(ResultValid), 0);
        chk("reset Ovf", int'(Ovf), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Reset while an ADD writes reg0: nothing may complete or pulse.
        InsSel = 2'd2; WE = 1'b1; RegAdd = 4'd0; InMuxAdd = 3'd2; CUconst = 8'h55;
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst Z", int'(Z), 1);
        chk("midrst CO", int'(CO), 0);
        chk("midrst Result", int'(Result), 0);
        @(posedge clk);
        #1;
        chk("midrst edge Result", int'(Result), 0);
        chk("midrst edge ResultValid", int'(ResultValid), 0);
        InsSel = 2'd0; WE = 1'b0;
        #3;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("postrst Result", int'(Result), 0);
        chk("postrst ResultValid", int'(ResultValid), 0);
        chk("postrst Z", int'(Z), 1);

        for (int i = 0; i < 400; i++) begin
            v.ins  = int'($urandom_range(0, 3));
            v.we   = int'($urandom_range(0, 1));
            v.radd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            v.oadd = int'($urandom_range(0, 15));
            v.src  = int'($urandom_range(0, 7));
            v.a    = int'($urandom_range(0, 255));
            v.c    = int'($urandom_range(0, 255));
            v.z = 0; v.co = 0; v.res = 0; v.rv = 0;
            apply(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
